// File: rtl/lockstep_checker.sv
// Lockstep comparator: aligns a ref stream to a skewed uut stream, ignores a warm-up window, then flags/counts divergences.
// Optional first-mismatch capture registers are built only when LOCKSTEP_FIRST_CAPTURE_EN is defined.
module lockstep_checker #(
    parameter int DATA_W = 8,
    parameter int SKEW   = 0,
    parameter int WARMUP = 2,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_en,
    input  logic              i_clear,
    input  logic              i_valid_ref,
    input  logic [DATA_W-1:0] i_data_ref,
    input  logic              i_valid_uut,
    input  logic [DATA_W-1:0] i_data_uut,
    output logic              o_armed,
    output logic              o_mismatch,
    output logic              o_sticky,
    output logic [CNT_W-1:0]  o_err_cnt,
    output logic [CNT_W-1:0]  o_cycle_cnt,
    output logic [CNT_W-1:0]  o_first_cycle,
    output logic [DATA_W-1:0] o_first_ref,
    output logic [DATA_W-1:0] o_first_uut
);

    localparam int WU_W    = (WARMUP < 2) ? 1 : $clog2(WARMUP);
    localparam int WU_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_ARMED  = 2'd1,
        S_FAILED = 2'd2
    } state_t;

    generate
        if (WARMUP < SKEW) begin : g_param_check
            $error("lockstep_checker: WARMUP must be >= SKEW");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_next;
    logic [WU_W-1:0]   r_wu_cnt;
    logic              w_wu_done;

    logic              w_ref_valid;
    logic [DATA_W-1:0] w_ref_data;
    logic              w_cmp;
    logic              w_diverge;
    logic              w_mismatch;

    logic              r_mismatch;
    logic              r_sticky;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_cycle_cnt;

    // Ref alignment: SKEW-deep delay line, or a plain wire when SKEW is 0.
    generate
        if (SKEW == 0) begin : g_no_skew
            assign w_ref_valid = i_valid_ref;
            assign w_ref_data  = i_data_ref;
        end else begin : g_skew
            for (genvar gi = 0; gi < SKEW; gi++) begin : g_stage
                logic              w_in_valid;
                logic [DATA_W-1:0] w_in_data;
                logic              r_valid;
                logic [DATA_W-1:0] r_data;

                if (gi == 0) begin : g_head
                    assign w_in_valid = i_valid_ref;
                    assign w_in_data  = i_data_ref;
                end else begin : g_tail
                    assign w_in_valid = g_stage[gi-1].r_valid;
                    assign w_in_data  = g_stage[gi-1].r_data;
                end

                always_ff @(posedge i_clk) begin
                    if (!i_reset_n) begin
                        r_valid <= 1'b0;
                        r_data  <= '0;
                    end else begin
                        r_valid <= w_in_valid;
                        r_data  <= w_in_data;
                    end
                end
            end
            assign w_ref_valid = g_stage[SKEW-1].r_valid;
            assign w_ref_data  = g_stage[SKEW-1].r_data;
        end
    endgenerate

    assign w_cmp      = (r_state != S_WARMUP) && i_en && (w_ref_valid || i_valid_uut);
    assign w_diverge  = (w_ref_valid != i_valid_uut) ||
                        (w_ref_valid && i_valid_uut && (w_ref_data != i_data_uut));
    assign w_mismatch = w_cmp && w_diverge;
    assign w_wu_done  = (r_wu_cnt == WU_W'(WU_LAST));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state  <= S_WARMUP;
            r_wu_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_WARMUP && !w_wu_done) begin
                r_wu_cnt <= r_wu_cnt + 1'b1;
            end
        end
    end

    // A clear in the same cycle as a mismatch discards that mismatch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WARMUP: if (w_wu_done) w_state_next = S_ARMED;
            S_ARMED:  if (w_mismatch && !i_clear) w_state_next = S_FAILED;
            S_FAILED: if (i_clear) w_state_next = S_ARMED;
            default:  w_state_next = S_WARMUP;
        endcase
    end

    always_comb begin
        o_armed = (r_state == S_ARMED) || (r_state == S_FAILED);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            r_mismatch  <= 1'b0;
            r_sticky    <= 1'b0;
            r_err_cnt   <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_mismatch <= w_mismatch;
            if (w_mismatch) begin
                r_sticky <= 1'b1;
                if (r_err_cnt != CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
            if (w_cmp && (r_cycle_cnt != CNT_MAX)) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
        end
    end

    assign o_mismatch  = r_mismatch;
    assign o_sticky    = r_sticky;
    assign o_err_cnt   = r_err_cnt;
    assign o_cycle_cnt = r_cycle_cnt;

`ifdef LOCKSTEP_FIRST_CAPTURE_EN
    logic [CNT_W-1:0]  r_first_cycle;
    logic [DATA_W-1:0] r_first_ref;
    logic [DATA_W-1:0] r_first_uut;

    // The cycle stamp is the count of compares that preceded the first divergence.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            r_first_cycle <= '0;
            r_first_ref   <= '0;
            r_first_uut   <= '0;
        end else if (w_mismatch && !r_sticky) begin
            r_first_cycle <= r_cycle_cnt;
            r_first_ref   <= w_ref_data;
            r_first_uut   <= i_data_uut;
        end
    end

    assign o_first_cycle = r_first_cycle;
    assign o_first_ref   = r_first_ref;
    assign o_first_uut   = r_first_uut;
`else
    assign o_first_cycle = '0;
    assign o_first_ref   = '0;
    assign o_first_uut   = '0;
`endif

endmodule

// File: tb/tb_lockstep_checker.sv
// Bench: two checker instances (skewed/16-bit and unskewed/4-bit) against a cycle-level behavioural model.
module tb_lockstep_checker;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus: index 0 = A (SKEW 3, WARMUP 4, CNT_W 16), 1 = B (SKEW 0, WARMUP 2, CNT_W 4)
    logic       rstn [2];
    logic       en   [2];
    logic       clr  [2];
    logic       vr   [2];
    logic       vu   [2];
    logic [7:0] dr   [2];
    logic [7:0] du   [2];

    logic        a_armed, a_mis, a_sticky;
    logic [15:0] a_err, a_cyc, a_fc;
    logic [7:0]  a_fr, a_fu;
    logic        b_armed, b_mis, b_sticky;
    logic [3:0]  b_err, b_cyc, b_fc;
    logic [7:0]  b_fr, b_fu;

    lockstep_checker #(.DATA_W(8), .SKEW(3), .WARMUP(4), .CNT_W(16)) u_dut_a (
        .i_clk(clk), .i_reset_n(rstn[0]), .i_en(en[0]), .i_clear(clr[0]),
        .i_valid_ref(vr[0]), .i_data_ref(dr[0]), .i_valid_uut(vu[0]), .i_data_uut(du[0]),
        .o_armed(a_armed), .o_mismatch(a_mis), .o_sticky(a_sticky),
        .o_err_cnt(a_err), .o_cycle_cnt(a_cyc), .o_first_cycle(a_fc),
        .o_first_ref(a_fr), .o_first_uut(a_fu)
    );

    lockstep_checker #(.DATA_W(8), .SKEW(0), .WARMUP(2), .CNT_W(4)) u_dut_b (
        .i_clk(clk), .i_reset_n(rstn[1]), .i_en(en[1]), .i_clear(clr[1]),
        .i_valid_ref(vr[1]), .i_data_ref(dr[1]), .i_valid_uut(vu[1]), .i_data_uut(du[1]),
        .o_armed(b_armed), .o_mismatch(b_mis), .o_sticky(b_sticky),
        .o_err_cnt(b_err), .o_cycle_cnt(b_cyc), .o_first_cycle(b_fc),
        .o_first_ref(b_fr), .o_first_uut(b_fu)
    );

    int skew_of [2] = '{3, 0};
    int warm_of [2] = '{4, 2};
    int max_of  [2] = '{65535, 15};

    int         m_n      [2];
    bit         m_hv     [2][8];
    logic [7:0] m_hd     [2][8];
    bit         m_mis    [2];
    bit         m_sticky [2];
    int         m_err    [2];
    int         m_cyc    [2];
    int         m_fc     [2];
    int         m_fr     [2];
    int         m_fu     [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    // Model: one clock edge worth of behaviour for instance k, using the inputs present at that edge.
    task automatic model_step(input int k);
        bit         av;
        logic [7:0] ad;
        bit         cmp;
        bit         mm;
        if (!rstn[k]) begin
            m_n[k] = 0;
            for (int i = 0; i < 8; i++) begin
                m_hv[k][i] = 1'b0;
                m_hd[k][i] = 8'h00;
            end
            m_mis[k] = 0; m_sticky[k] = 0; m_err[k] = 0; m_cyc[k] = 0;
            m_fc[k] = 0; m_fr[k] = 0; m_fu[k] = 0;
            return;
        end
        if (skew_of[k] == 0) begin
            av = vr[k];
            ad = dr[k];
        end else begin
            av = m_hv[k][skew_of[k]-1];
            ad = m_hd[k][skew_of[k]-1];
        end
        for (int i = 7; i > 0; i--) begin
            m_hv[k][i] = m_hv[k][i-1];
            m_hd[k][i] = m_hd[k][i-1];
        end
        m_hv[k][0] = vr[k];
        m_hd[k][0] = dr[k];

        cmp = (m_n[k] >= warm_of[k]) && en[k] && (av || vu[k]);
        mm  = cmp && ((av != vu[k]) || (av && vu[k] && (ad != du[k])));
        if (clr[k]) begin
            m_mis[k] = 0; m_sticky[k] = 0; m_err[k] = 0; m_cyc[k] = 0;
            m_fc[k] = 0; m_fr[k] = 0; m_fu[k] = 0;
        end else begin
            m_mis[k] = mm;
            if (mm) begin
                if (!m_sticky[k]) begin
                    m_fc[k] = m_cyc[k];
                    m_fr[k] = int'(ad);
                    m_fu[k] = int'(du[k]);
                end
                m_sticky[k] = 1;
                if (m_err[k] < max_of[k]) m_err[k]++;
            end
            if (cmp && m_cyc[k] < max_of[k]) m_cyc[k]++;
        end
        if (m_n[k] < 1000000) m_n[k]++;
    endtask

    function automatic int cap_exp(input int v);
`ifdef LOCKSTEP_FIRST_CAPTURE_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic compare_all();
        chk("A.o_armed",       int'(a_armed),  int'(m_n[0] >= warm_of[0]));
        chk("A.o_mismatch",    int'(a_mis),    int'(m_mis[0]));
        chk("A.o_sticky",      int'(a_sticky), int'(m_sticky[0]));
        chk("A.o_err_cnt",     int'(a_err),    m_err[0]);
        chk("A.o_cycle_cnt",   int'(a_cyc),    m_cyc[0]);
        chk("A.o_first_cycle", int'(a_fc),     cap_exp(m_fc[0]));
        chk("A.o_first_ref",   int'(a_fr),     cap_exp(m_fr[0]));
        chk("A.o_first_uut",   int'(a_fu),     cap_exp(m_fu[0]));
        chk("B.o_armed",       int'(b_armed),  int'(m_n[1] >= warm_of[1]));
        chk("B.o_mismatch",    int'(b_mis),    int'(m_mis[1]));
        chk("B.o_sticky",      int'(b_sticky), int'(m_sticky[1]));
        chk("B.o_err_cnt",     int'(b_err),    m_err[1]);
        chk("B.o_cycle_cnt",   int'(b_cyc),    m_cyc[1]);
        chk("B.o_first_cycle", int'(b_fc),     cap_exp(m_fc[1]));
        chk("B.o_first_ref",   int'(b_fr),     cap_exp(m_fr[1]));
        chk("B.o_first_uut",   int'(b_fu),     cap_exp(m_fu[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic idle(input int k);
        en[k] = 1'b1; clr[k] = 1'b0;
        vr[k] = 1'b0; vu[k] = 1'b0; dr[k] = 8'h00; du[k] = 8'h00;
    endtask

    task automatic run_stream(input bit corrupt);
        for (int t = 0; t < 67; t++) begin
            vr[0] = (t < 64);
            dr[0] = (t < 64) ? 8'(t) : 8'h00;
            vu[0] = (t >= 3);
            du[0] = (t >= 3) ? 8'(t - 3) : 8'h00;
            if (corrupt && t == 19) du[0] = 8'hA5;
            tick();
            if (corrupt && t == 19) chk("A.corrupt_pulse", int'(a_mis), 1);
        end
        idle(0);
        tick();
    endtask

    task automatic rand_inputs(input int k);
        bit         pv;
        logic [7:0] pd;
        vr[k] = ($urandom_range(0, 3) != 0);
        dr[k] = 8'($urandom_range(0, 255));
        if (skew_of[k] == 0) begin
            pv = vr[k];
            pd = dr[k];
        end else begin
            pv = m_hv[k][skew_of[k]-1];
            pd = m_hd[k][skew_of[k]-1];
        end
        if ($urandom_range(0, 3) != 0) begin
            vu[k] = pv;
            du[k] = pd;
        end else begin
            vu[k] = ($urandom_range(0, 1) != 0);
            du[k] = 8'($urandom_range(0, 3));
        end
        en[k]   = ($urandom_range(0, 9) != 0);
        clr[k]  = ($urandom_range(0, 29) == 0);
        rstn[k] = ($urandom_range(0, 99) != 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rstn[k] = 1'b0;
            idle(k);
        end
        repeat (3) tick();
        chk("B.reset_armed", int'(b_armed), 0);
        chk("B.reset_err",   int'(b_err),   0);
        chk("A.reset_cyc",   int'(a_cyc),   0);

        // Warm-up on B: divergent data during the window must not compare
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        vr[1] = 1'b1; dr[1] = 8'h11; vu[1] = 1'b1; du[1] = 8'h22;
        tick();
        chk("B.warm_armed_c1", int'(b_armed), 0);
        tick();
        chk("B.warm_armed_c2", int'(b_armed), 1);
        chk("B.warm_mis",      int'(b_mis),   0);
        chk("B.warm_err",      int'(b_err),   0);

        // Saturation: 20 continuous mismatches on a 4-bit counter
        repeat (20) tick();
        chk("B.sat_err",    int'(b_err),    15);
        chk("B.sat_sticky", int'(b_sticky), 1);

        // Clear in a mismatch cycle wins
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        chk("B.clr_err",    int'(b_err),    0);
        chk("B.clr_sticky", int'(b_sticky), 0);
        chk("B.clr_mis",    int'(b_mis),    0);
        chk("B.clr_armed",  int'(b_armed),  1);

        // Valid-only divergence counts; both-invalid does not compare
        vr[1] = 1'b1; vu[1] = 1'b0; dr[1] = 8'h5A; du[1] = 8'h5A;
        tick();
        chk("B.vdiv_mis", int'(b_mis), 1);
        chk("B.vdiv_err", int'(b_err), 1);
        vr[1] = 1'b0; vu[1] = 1'b0; dr[1] = 8'h01; du[1] = 8'h02;
        tick();
        chk("B.inv_err", int'(b_err), 1);
        chk("B.inv_cyc", int'(b_cyc), 1);

        // Reset while FAILED, then warm-up restarts
        rstn[1] = 1'b0;
        tick();
        chk("B.rst_armed",  int'(b_armed),  0);
        chk("B.rst_sticky", int'(b_sticky), 0);
        chk("B.rst_err",    int'(b_err),    0);
        rstn[1] = 1'b1;
        tick();
        chk("B.rewarm_c1", int'(b_armed), 0);
        tick();
        chk("B.rewarm_c2", int'(b_armed), 1);
        idle(1);

        // Aligned stream on A with uut lagging by 3
        run_stream(1'b0);
        chk("A.stream_cyc",    int'(a_cyc),    64);
        chk("A.stream_err",    int'(a_err),    0);
        chk("A.stream_sticky", int'(a_sticky), 0);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;

        // Single corruption at index 16
        run_stream(1'b1);
        chk("A.corrupt_err", int'(a_err), 1);
        chk("A.corrupt_fc",  int'(a_fc),  cap_exp(16));
        chk("A.corrupt_fr",  int'(a_fr),  cap_exp(8'h10));
        chk("A.corrupt_fu",  int'(a_fu),  cap_exp(8'hA5));

        // Randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            rand_inputs(0);
            rand_inputs(1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lockstep_checker.md
# lockstep_checker

Parametrised, synthesizable lockstep comparator for mutation and equivalence campaigns. It aligns a reference output stream and a unit-under-test output stream that may differ by a fixed pipeline skew. It ignores a warm-up window after reset, then flags, counts and optionally captures divergences. It sits between two instances of the same design (reference and mutated) in simulation benches and on-FPGA self-check harnesses.

## Interface
- DATA_W, 8: width of each compared data word.
- SKEW, 0: cycles by which the uut stream lags the ref stream. The ref path is delayed by SKEW to align.
- WARMUP, 2: cycles after reset release during which no compare happens. Must be >= SKEW; otherwise elaboration fails.
- CNT_W, 16: width of the error and cycle counters.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_en  in  1  compare enable. When low, no compare and counters hold; the delay line still shifts.
- i_clear  in  1  synchronous clear of sticky flag, counters and capture; does not restart warm-up.
- i_valid_ref  in  1  ref sample valid.
- i_data_ref  in  DATA_W  ref sample.
- i_valid_uut  in  1  uut sample valid.
- i_data_uut  in  DATA_W  uut sample.
- o_armed  out  1  high in ARMED or FAILED.
- o_mismatch  out  1  registered one-cycle pulse per divergent compare.
- o_sticky  out  1  set on first mismatch, held until i_clear or reset.
- o_err_cnt  out  CNT_W  saturating mismatch count.
- o_cycle_cnt  out  CNT_W  saturating count of compared cycles.
- o_first_cycle  out  CNT_W  o_cycle_cnt value at the first mismatch.
- o_first_ref  out  DATA_W  aligned ref data at the first mismatch.
- o_first_uut  out  DATA_W  uut data at the first mismatch.

## Operation
- **FSM states:** WARMUP, ARMED, FAILED.
  - Reset forces WARMUP with the warm-up counter at 0.
  - WARMUP → ARMED after WARMUP cycles, counting cycles with reset deasserted regardless of i_en.
  - ARMED → FAILED on a mismatch.
  - FAILED → ARMED on i_clear.
  - Comparison continues in FAILED.
- **Alignment:** ref valid/data pass through a SKEW-deep shift register (valid bits reset to 0). With SKEW=0 the path is a wire.
- **Compare cycle:** state ≠ WARMUP, i_en=1, and (aligned ref valid OR uut valid).
- **Mismatch:** in a compare cycle, the valids differ, or both are valid and the data differ. Both invalid means no compare.
- **Counters:**
  - o_cycle_cnt increments on each compare cycle.
  - o_err_cnt increments on each mismatch.
  - Both saturate at 2^CNT_W−1 and never wrap.
- **Capture:** first-mismatch registers load only when o_sticky is 0.
- **i_clear and mismatch in the same cycle:** i_clear wins. Counters, sticky and capture go to 0, and that cycle's mismatch is discarded (no o_mismatch pulse).
- **Reset mid-operation:** all state is cleared, the delay line is flushed, and warm-up restarts.

## Timing
- Reset values: every output is 0.
- o_mismatch, o_sticky, counters and capture update one cycle after the compare cycle. For a uut sample at cycle t (paired with the ref sample from t−SKEW), the flag is visible at t+1.
- o_sticky rises in the same cycle as the first o_mismatch pulse.
- o_armed rises exactly WARMUP cycles after the first cycle with i_reset_n=1.
- Back-to-back mismatches give back-to-back o_mismatch pulses, +1 count each.

## Configuration
- Macro: LOCKSTEP_FIRST_CAPTURE_EN.
  - **Defined:** the first-mismatch capture registers are built as described.
  - **Undefined:** o_first_cycle, o_first_ref and o_first_uut are tied to 0 and no capture logic is built. All other behaviour and all ports are unchanged.

## Test plan
- **Warm-up:** DATA_W=8, SKEW=0, WARMUP=2. Release reset, then drive ref=0x11, uut=0x22 for 2 cycles → no o_mismatch; o_armed=1 from cycle 2; o_err_cnt=0.
- **Aligned stream:** SKEW=3. Drive identical incrementing streams 0x00..0x3F, with uut lagging by 3 → o_sticky=0, o_err_cnt=0, o_cycle_cnt=64.
- **Single corruption:** as above, but uut=0xA5 instead of 0x10 → one o_mismatch pulse one cycle later; o_err_cnt=1; o_first_ref=0x10, o_first_uut=0xA5, o_first_cycle=16 (with capture enabled; 0 without).
- **Valid-only divergence:** ref valid=1, uut valid=0, same data → mismatch counted. Both valids 0 with different data → no compare, counters hold.
- **Saturation and clear:** CNT_W=4, continuous mismatches for 20 cycles → o_err_cnt=15, held. Assert i_clear in a mismatch cycle → next cycle o_err_cnt=0, o_sticky=0, no pulse, state ARMED.
- **Reset mid-run:** assert i_reset_n=0 while FAILED → next cycle all outputs 0 and o_armed=0. After release, o_armed returns only after WARMUP cycles.
